scanline_fill: RTL and testbench

// - Consumes the 64x64 outline bitmap produced by the Bresenham line stage.
//   It is started by bla_done.
// - Emits the bitmap row by row, over a valid/ready handshake, to the frame-buffer writer.
// - fill_mode=1: each row becomes one solid span, from its leftmost to its rightmost set pixel.

---
 rtl/scanline_fill_if.sv | 24 ++
 rtl/scanline_fill.sv | 149 ++++++++++++++
 tb/tb_scanline_fill.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scanline_fill_if.sv
// Row output channel of the scanline filler: one bitmap row per valid/ready transfer.
interface scanline_fill_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 6
);
    logic [WIDTH-1:0] row_data;
    logic [AW-1:0]    row_addr;
    logic             row_valid;
    logic             row_ready;

    modport master (
        output row_data,
        output row_addr,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_addr,
        input  row_valid,
        output row_ready
    );
endinterface

// File: rtl/scanline_fill.sv
// Captures a WIDTHxHEIGHT outline bitmap and emits it row by row, either unchanged
// or with each row widened to one solid span between its outermost set pixels.
module scanline_fill #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    fill_start,
    input  logic                    fill_mode,
    input  logic [WIDTH*HEIGHT-1:0] line_buffer,
    scanline_fill_if.master         row_if,
    output logic                    busy,
    output logic                    fill_done
);
    localparam int AW = $clog2(HEIGHT);
    localparam int XW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH*HEIGHT-1:0] bitmap_q, bitmap_d;
    logic                    mode_q, mode_d;
    logic [AW-1:0]           y_q, y_d;
    logic [WIDTH-1:0]        row_data_q, row_data_d;
    logic [AW-1:0]           row_addr_q, row_addr_d;
    logic                    row_valid_q, row_valid_d;
    logic                    busy_q, busy_d;
    logic                    fill_done_q, fill_done_d;
    logic [WIDTH-1:0]        cur_row_s;

    // Solid span from the lowest to the highest set bit; an empty row stays empty.
    function automatic logic [WIDTH-1:0] span_fill(input logic [WIDTH-1:0] row);
        logic [XW-1:0]    lo;
        logic [XW-1:0]    hi;
        logic [WIDTH-1:0] mask;
        lo   = '0;
        hi   = '0;
        mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (row[i]) lo = XW'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (row[i]) hi = XW'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (XW'(i) >= lo) && (XW'(i) <= hi);
        end
        return (|row) ? mask : '0;
    endfunction

    // Row y of the captured bitmap, selected as a one-hot OR over all rows.
    always_comb begin
        cur_row_s = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            cur_row_s = cur_row_s |
                        (bitmap_q[r*WIDTH +: WIDTH] & {WIDTH{y_q == AW'(r)}});
        end
    end

    // Next-state and output logic of the frame sequencer.
    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        mode_d      = mode_q;
        y_d         = y_q;
        row_data_d  = row_data_q;
        row_addr_d  = row_addr_q;
        row_valid_d = row_valid_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    bitmap_d = line_buffer;
                    mode_d   = fill_mode;
                    y_d      = '0;
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                row_data_d  = mode_q ? span_fill(cur_row_s) : cur_row_s;
                row_addr_d  = y_q;
                row_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                // Data and address hold until the transfer completes.
                if (row_if.row_ready) begin
                    row_valid_d = 1'b0;
                    if (y_q == AW'(HEIGHT - 1)) begin
                        state_d = DONE;
                    end else begin
                        y_d     = y_q + AW'(1);
                        state_d = CALC;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                row_valid_d = 1'b0;
            end
        endcase
        busy_d      = (state_d != IDLE);
        fill_done_d = (state_d == DONE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bitmap_q    <= '0;
            mode_q      <= 1'b0;
            y_q         <= '0;
            row_data_q  <= '0;
            row_addr_q  <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            mode_q      <= mode_d;
            y_q         <= y_d;
            row_data_q  <= row_data_d;
            row_addr_q  <= row_addr_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign row_if.row_data  = row_data_q;
    assign row_if.row_addr  = row_addr_q;
    assign row_if.row_valid = row_valid_q;
    assign busy             = busy_q;
    assign fill_done        = fill_done_q;

endmodule

// File: tb/tb_scanline_fill.sv
// Scoreboard bench for scanline_fill: stimulus pushes expected rows, a negedge monitor checks them.
module tb_scanline_fill;
    localparam int W = 64;
    localparam int H = 64;

    logic         clk;
    logic         n_rst;
    logic         fill_start;
    logic         fill_mode;
    logic [W*H-1:0] lb;
    logic         busy;
    logic         fill_done;

    scanline_fill_if #(.WIDTH(W), .AW(6)) rif ();

    scanline_fill #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .fill_start  (fill_start),
        .fill_mode   (fill_mode),
        .line_buffer (lb),
        .row_if      (rif),
        .busy        (busy),
        .fill_done   (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [69:0] exp_q[$];
    logic [63:0] exp_rows[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic clear_exp();
        for (int r = 0; r < 64; r++) exp_rows[r] = 64'h0;
    endtask

    task automatic push_exp();
        for (int r = 0; r < 64; r++) exp_q.push_back({6'(r), exp_rows[r]});
    endtask

    task automatic set_px(input int x, input int y);
        lb[64*y + x] = 1'b1;
    endtask

    // Pulse fill_start; returns at E0 + 1.
    task automatic start_frame(input logic mode);
        fill_mode  = mode;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (fill_done !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", 64'(fill_done), 64'h1);
        @(posedge clk);
        #1;
        check("busy_after_done", 64'(busy), 64'h0);
        check("queue_empty", 64'(exp_q.size()), 64'h0);
    endtask

    // Scoreboard monitor: every accepted row is compared against the queue head.
    always @(negedge clk) begin
        logic [69:0] e;
        if (n_rst === 1'b1) begin
            if (rif.row_valid === 1'b1 && rif.row_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_row: got addr %0d data %h expected none",
                             rif.row_addr, rif.row_data);
                end else begin
                    e = exp_q.pop_front();
                    check("row_addr", 64'(rif.row_addr), 64'(e[69:64]));
                    check("row_data", rif.row_data, e[63:0]);
                end
            end
            if (fill_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        n_rst         = 1'b0;
        fill_start    = 1'b0;
        fill_mode     = 1'b0;
        lb            = '0;
        rif.row_ready = 1'b0;
        #1;
        check("rst_valid", 64'(rif.row_valid), 64'h0);
        check("rst_data",  rif.row_data, 64'h0);
        check("rst_addr",  64'(rif.row_addr), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);
        check("rst_done",  64'(fill_done), 64'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through with exact fill_done timing.
        lb = '0;
        for (int x = 10; x <= 20; x++) set_px(x, 5);
        clear_exp();
        exp_rows[5] = 64'h0000_0000_001F_FC00;
        push_exp();
        rif.row_ready = 1'b1;
        d0 = done_cnt;
        start_frame(1'b0);
        check("busy_after_start", 64'(busy), 64'h1);
        repeat (127) @(posedge clk);
        #1;
        check("done_e127", 64'(fill_done), 64'h0);
        @(posedge clk);
        #1;
        check("done_e128", 64'(fill_done), 64'h1);
        check("busy_in_done", 64'(busy), 64'h1);
        @(posedge clk);
        #1;
        check("done_e129", 64'(fill_done), 64'h0);
        check("busy_e129", 64'(busy), 64'h0);
        check("done_count_t1", 64'(done_cnt - d0), 64'h1);
        check("queue_empty_t1", 64'(exp_q.size()), 64'h0);

        // Span fill between two far-apart pixels.
        lb = '0;
        set_px(2, 3);
        set_px(60, 3);
        clear_exp();
        exp_rows[3] = 64'h1FFF_FFFF_FFFF_FFFC;
        push_exp();
        start_frame(1'b1);
        wait_done(400);

        // Row edges and a single pixel, with backpressure on row 0.
        lb = '0;
        set_px(0, 0);
        set_px(63, 0);
        set_px(7, 1);
        clear_exp();
        exp_rows[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_rows[1] = 64'h0000_0000_0000_0080;
        push_exp();
        rif.row_ready = 1'b0;
        start_frame(1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(rif.row_valid), 64'h1);
            check("bp_addr",  64'(rif.row_addr), 64'h0);
            check("bp_data",  rif.row_data, 64'hFFFF_FFFF_FFFF_FFFF);
            @(posedge clk);
            #1;
        end
        rif.row_ready = 1'b1;
        wait_done(400);

        // A second start mid-frame must be ignored.
        lb = '0;
        set_px(1, 2);
        clear_exp();
        exp_rows[2] = 64'h0000_0000_0000_0002;
        push_exp();
        d0 = done_cnt;
        start_frame(1'b0);
        repeat (20) @(posedge clk);
        #1;
        lb = '1;
        start_frame(1'b1);
        wait_done(400);
        repeat (5) @(posedge clk);
        #1;
        check("done_count_busy", 64'(done_cnt - d0), 64'h1);
        check("busy_idle_after", 64'(busy), 64'h0);

        // Reset during row 30, then a complete fresh frame.
        lb = '0;
        for (int r = 0; r < 64; r++) begin
            set_px(r, r);
            set_px(63, r);
        end
        clear_exp();
        for (int r = 0; r < 64; r++) exp_rows[r] = 64'hFFFF_FFFF_FFFF_FFFF << r;
        push_exp();
        d0 = done_cnt;
        start_frame(1'b1);
        n = 0;
        while (!(rif.row_valid === 1'b1 && rif.row_addr === 6'd30) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("row30_reached", 64'(rif.row_addr), 64'd30);
        n_rst = 1'b0;
        #1;
        check("arst_valid", 64'(rif.row_valid), 64'h0);
        check("arst_data",  rif.row_data, 64'h0);
        check("arst_addr",  64'(rif.row_addr), 64'h0);
        check("arst_busy",  64'(busy), 64'h0);
        check("arst_done",  64'(fill_done), 64'h0);
        check("rows_left_at_reset", 64'(exp_q.size()), 64'd34);
        exp_q.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (140) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(done_cnt - d0), 64'h0);
        check("idle_after_reset", 64'(rif.row_valid), 64'h0);
        push_exp();
        d0 = done_cnt;
        start_frame(1'b1);
        wait_done(400);
        check("done_count_rerun", 64'(done_cnt - d0), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
